// File: rtl/ats_mc.sv
// ats_mc: queued arithmetic engine (add/sub/shift-add mul/pass) behind a DEPTH-entry request FIFO.
// Build option: define ATS_SAT_EN to clamp out-of-range results instead of wrapping.
module ats_mc #(
   parameter int unsigned W     = 16,
   parameter int unsigned DW    = 24,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [W-1:0]  ctrlA,
   input  logic [W-1:0]  ctrlB,
   output logic          ready,
   output logic [1:0]    stat,
   output logic [DW-1:0] data
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = W - 2;
   localparam int unsigned NW = (BW > 1) ? $clog2(BW) : 1;
   // Wide enough for a full W x (W-2) product and for any DW.
   localparam int unsigned XW = (DW > 2 * W) ? DW : 2 * W;

   localparam logic [1:0] OpAdd = 2'b00;
   localparam logic [1:0] OpSub = 2'b01;
   localparam logic [1:0] OpMul = 2'b10;

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e            state_q, state_d;
   logic [2*W-1:0]    mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [CW-1:0]     cnt_q;
   logic [1:0]        opc_q;
   logic [W-1:0]      opa_q;
   logic [BW-1:0]     mplier_q;
   logic [XW-1:0]     mcand_q, acc_q;
   logic [NW-1:0]     step_q;
   logic [DW-1:0]     data_q;
   logic              ovf_q, drop_q;

   logic              push, pop, fin, under, ovf, err;
   logic [2*W-1:0]    head;
   logic [XW-1:0]     acc_nxt, full;
   logic [DW-1:0]     res;

   assign ready   = (cnt_q < CW'(DEPTH));
   assign push    = req && ready;
   assign pop     = (state_q != StExec) && (cnt_q != '0);
   assign head    = mem_q[rptr_q];
   assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign data    = data_q;

   always_comb begin
      state_d = state_q;
      fin     = 1'b0;
      case (state_q)
         StIdle: if (pop) state_d = StExec;
         StExec: begin
            if (opc_q != OpMul || step_q == NW'(BW - 1)) begin
               fin     = 1'b1;
               state_d = StDone;
            end
         end
         StDone:  state_d = pop ? StExec : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      full  = '0;
      under = 1'b0;
      case (opc_q)
         OpAdd: full = XW'(opa_q) + XW'(mplier_q);
         OpSub: begin
            full  = XW'(opa_q) - XW'(mplier_q);
            under = (opa_q < {2'b00, mplier_q});
         end
         OpMul:   full = acc_nxt;
         default: full = XW'(opa_q);
      endcase
      // A negative difference sets upper bits too, so sub is flagged only by under.
      ovf = (opc_q != OpSub) && ((full >> DW) != '0);
      err = ovf || under;
`ifdef ATS_SAT_EN
      if (under)    res = '0;
      else if (ovf) res = '1;
      else          res = full[DW-1:0];
`else
      res = full[DW-1:0];
`endif
   end

   always_comb begin
      stat = 2'b00;
      if (drop_q) stat = 2'b11;
      else begin
         case (state_q)
            StExec:  stat = 2'b01;
            StDone:  stat = ovf_q ? 2'b11 : 2'b10;
            default: stat = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) mem_q[wptr_q] <= {ctrlA, ctrlB};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         opc_q    <= '0;
         opa_q    <= '0;
         mplier_q <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         step_q   <= '0;
         data_q   <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= req && !ready;
         cnt_q   <= cnt_q + CW'(push) - CW'(pop);
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop) begin
            rptr_q   <= rptr_q + AW'(1);
            opa_q    <= head[2*W-1:W];
            opc_q    <= head[W-1:W-2];
            mplier_q <= head[BW-1:0];
            mcand_q  <= XW'(head[2*W-1:W]);
            acc_q    <= '0;
            step_q   <= '0;
         end else if (state_q == StExec) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            step_q   <= step_q + NW'(1);
         end
         if (fin) begin
            data_q <= res;
            ovf_q  <= err;
         end
      end
   end
endmodule
